// File: rtl/lsram_pp_pkg.sv
// Shared types, RAM geometry and address helpers for the LSRAM ping-pong controller.
package lsram_pp_pkg;

  localparam int RAM_AW = 11;
  localparam int RAM_DW = 64;

  // Per-bank lifecycle: written once, read once, then recycled.
  typedef enum logic [1:0] {
    StEmpty,
    StFilling,
    StFull,
    StDraining
  } bank_st_e;

  // Reverse the low logn bits of x; bits at and above logn come out as zero.
  function automatic logic [RAM_AW-1:0] bitrev(input int logn, input logic [RAM_AW-1:0] x);
    logic [RAM_AW-1:0] r;
    r = '0;
    for (int i = 0; i < RAM_AW; i++) begin
      for (int j = 0; j < RAM_AW; j++) begin
        if (i < logn && j == logn - 1 - i) r[i] = x[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pp_skid_fifo.sv
// First-word-fall-through skid FIFO catching RAM read data; exposes occupancy for credit checks.
module pp_skid_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 65,
  localparam int unsigned OccW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic [OccW-1:0]  occ_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             pop_ok;

  // Pointer and occupancy next-state; pops on an empty FIFO are ignored.
  always_comb begin
    pop_ok = pop_i & (occ_q != '0);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    if (pop_ok) rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    occ_d = occ_q + OccW'(push_i) - OccW'(pop_ok);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Data storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rvalid_o = (occ_q != '0);
  assign rdata_o  = mem_q[rptr_q];
  assign occ_o    = occ_q;

endmodule

// File: rtl/lsram_pingpong_ctrl.sv
// Ping-pong scheduler for two LSRAM banks: writer fills one bank while the reader drains the other.
module lsram_pingpong_ctrl
  import lsram_pp_pkg::*;
#(
  parameter int unsigned LOG_N  = 11,
  parameter int unsigned DW     = 64,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned BITREV = 0
) (
  input  logic              CLK,
  input  logic              nGrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [1:0]        ram_wrb,
  output logic [DW-1:0]     ram_di,
  output logic [RAM_AW-1:0] ram_raddr,
  output logic              ram_rsel,
  input  logic [DW-1:0]     ram_do0,
  input  logic [DW-1:0]     ram_do1,
  output logic              ram_do_en,
  output logic              ram_do_rst
);

  localparam int unsigned FifoDepth = RD_LAT + 2;
  localparam int unsigned OccW      = $clog2(FifoDepth + 1);
  localparam int unsigned CntW      = $clog2(FifoDepth + RD_LAT + 1);

  bank_st_e         bank_q [2];
  bank_st_e         bank_d [2];
  logic [LOG_N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             wsel_q, wsel_d, rsel_q, rsel_d;
  logic             psel_q, psel_d;  // bank owning the sample at the FIFO head
  logic             run_q;           // holds in_ready low through reset
  logic             pipe_vld_q  [RD_LAT];
  logic             pipe_bank_q [RD_LAT];
  logic             pipe_last_q [RD_LAT];

  logic            wr_fire, wr_last, rd_issue, rd_last, rd_bank_ok, pop, drain_done;
  logic [CntW-1:0] inflight;
  logic [OccW-1:0] occ;
  logic            fifo_push;
  logic [DW:0]     fifo_wdata, fifo_rdata;

  // Handshakes, read credit and issue qualification.
  always_comb begin
    in_ready   = run_q & ((bank_q[wsel_q] == StEmpty) | (bank_q[wsel_q] == StFilling));
    wr_fire    = in_valid & in_ready;
    wr_last    = (wcnt_q == '1);
    rd_last    = (rcnt_q == '1);
    // A DRAINING bank with rcnt=0 is fully issued and only waits for the FIFO to empty.
    rd_bank_ok = (bank_q[rsel_q] == StFull) |
                 ((bank_q[rsel_q] == StDraining) & (rcnt_q != '0));
    inflight   = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CntW'(pipe_vld_q[i]);
    rd_issue   = rd_bank_ok & ((CntW'(occ) + inflight) < CntW'(FifoDepth));
    pop        = out_valid & out_ready;
    drain_done = pop & out_last;
  end

  // Bank lifecycle and counter next-state; the three events always hit banks in distinct states.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (wr_fire) bank_d[wsel_q] = wr_last ? StFull : StFilling;
    if (rd_issue && bank_q[rsel_q] == StFull) bank_d[rsel_q] = StDraining;
    if (drain_done) bank_d[psel_q] = StEmpty;
    wcnt_d = wr_fire ? wcnt_q + 1'b1 : wcnt_q;
    wsel_d = wsel_q ^ (wr_fire & wr_last);
    rcnt_d = rd_issue ? rcnt_q + 1'b1 : rcnt_q;
    rsel_d = rsel_q ^ (rd_issue & rd_last);
    psel_d = psel_q ^ drain_done;
  end

  // Bank, counter and select registers.
  always_ff @(posedge CLK) begin
    if (!nGrst) begin
      bank_q[0] <= StEmpty;
      bank_q[1] <= StEmpty;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      psel_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      psel_q    <= psel_d;
      run_q     <= 1'b1;
    end
  end

  // In-flight tag pipe matching the RAM read latency.
  always_ff @(posedge CLK) begin
    if (!nGrst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_bank_q[i] <= 1'b0;
        pipe_last_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_issue;
      pipe_bank_q[0] <= rsel_q;
      pipe_last_q[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_bank_q[i] <= pipe_bank_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // RAM-side drive: write strobe only on a transfer, read address optionally bit-reversed.
  always_comb begin
    ram_wrb = '0;
    if (wr_fire) ram_wrb[wsel_q] = 1'b1;
    ram_waddr  = RAM_AW'(wcnt_q);
    ram_di     = in_data;
    ram_raddr  = (BITREV != 0) ? bitrev(int'(LOG_N), RAM_AW'(rcnt_q)) : RAM_AW'(rcnt_q);
    ram_rsel   = rsel_q;
    ram_do_en  = 1'b1;
    ram_do_rst = ~nGrst;
    fifo_push  = pipe_vld_q[RD_LAT-1];
    fifo_wdata = {pipe_last_q[RD_LAT-1], pipe_bank_q[RD_LAT-1] ? ram_do1 : ram_do0};
  end

  pp_skid_fifo #(
    .Depth (FifoDepth),
    .Width (DW + 1)
  ) u_skid (
    .clk_i    (CLK),
    .rst_ni   (nGrst),
    .push_i   (fifo_push),
    .wdata_i  (fifo_wdata),
    .pop_i    (pop),
    .rvalid_o (out_valid),
    .rdata_o  (fifo_rdata),
    .occ_o    (occ)
  );

  assign out_data   = fifo_rdata[DW-1:0];
  assign out_last   = fifo_rdata[DW];
  assign frame_done = drain_done;

endmodule

// File: tb/tb_lsram_pingpong_ctrl.sv
// Bench: two controllers (linear and bit-reversed read) with RAM models, shared stimulus,
// per-instance scoreboards fed from a frame-level reference model.
module tb_lsram_pingpong_ctrl;

  localparam int N = 8;

  logic CLK = 1'b0;
  logic nGrst, in_valid, out_ready;
  logic [63:0] in_data;
  int rdy_mode;

  logic        in_ready_w [2];
  logic        out_valid_w [2];
  logic [63:0] out_data_w [2];
  logic        out_last_w [2];
  logic        frame_done_w [2];
  logic [10:0] ram_waddr_w [2];
  logic [1:0]  ram_wrb_w [2];
  logic [63:0] ram_di_w [2];
  logic [10:0] ram_raddr_w [2];
  logic        ram_rsel_w [2];
  logic [63:0] do0_w [2];
  logic [63:0] do1_w [2];
  logic        do_en_w [2];
  logic        do_rst_w [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  lsram_pingpong_ctrl #(.LOG_N(3), .DW(64), .RD_LAT(2), .BITREV(0)) u_dut_lin (
    .CLK(CLK), .nGrst(nGrst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_data(out_data_w[0]), .out_last(out_last_w[0]), .frame_done(frame_done_w[0]),
    .ram_waddr(ram_waddr_w[0]), .ram_wrb(ram_wrb_w[0]), .ram_di(ram_di_w[0]),
    .ram_raddr(ram_raddr_w[0]), .ram_rsel(ram_rsel_w[0]), .ram_do0(do0_w[0]),
    .ram_do1(do1_w[0]), .ram_do_en(do_en_w[0]), .ram_do_rst(do_rst_w[0])
  );

  lsram_pingpong_ctrl #(.LOG_N(3), .DW(64), .RD_LAT(2), .BITREV(1)) u_dut_rev (
    .CLK(CLK), .nGrst(nGrst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_data(out_data_w[1]), .out_last(out_last_w[1]), .frame_done(frame_done_w[1]),
    .ram_waddr(ram_waddr_w[1]), .ram_wrb(ram_wrb_w[1]), .ram_di(ram_di_w[1]),
    .ram_raddr(ram_raddr_w[1]), .ram_rsel(ram_rsel_w[1]), .ram_do0(do0_w[1]),
    .ram_do1(do1_w[1]), .ram_do_en(do_en_w[1]), .ram_do_rst(do_rst_w[1])
  );

  // Two-port RAM model: registered read address, then registered output (latency 2).
  logic [63:0] mem [2][2][N];
  logic [10:0] ra_q [2];
  logic [63:0] do_q [2][2];

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (ram_wrb_w[k][b]) mem[k][b][ram_waddr_w[k][2:0]] <= ram_di_w[k];
        if (do_rst_w[k]) do_q[k][b] <= '0;
        else if (do_en_w[k]) do_q[k][b] <= mem[k][b][ra_q[k][2:0]];
      end
      ra_q[k] <= ram_raddr_w[k];
    end
  end

  assign do0_w[0] = do_q[0][0];
  assign do1_w[0] = do_q[0][1];
  assign do0_w[1] = do_q[1][0];
  assign do1_w[1] = do_q[1][1];

  task automatic chk(input string nm, input int k, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int rev3(input int x);
    int r = 0;
    for (int b = 0; b < 3; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  // Reference model: a completed frame yields N samples in read order, last on the N-th.
  logic [64:0] exp_q [2][$];
  logic [63:0] wbuf [2][$];
  logic        stalled [2];
  logic [64:0] held [2];
  int          pos [2];

  initial begin
    logic [64:0] e;
    int idx;
    for (int k = 0; k < 2; k++) begin stalled[k] = 0; pos[k] = 0; end
    forever begin
      @(negedge CLK);
      if (!nGrst) begin
        for (int k = 0; k < 2; k++) begin
          exp_q[k].delete(); wbuf[k].delete(); stalled[k] = 0; pos[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (in_valid && in_ready_w[k]) begin
            wbuf[k].push_back(in_data);
            if (wbuf[k].size() == N) begin
              for (int i = 0; i < N; i++) begin
                idx = (k == 1) ? rev3(i) : i;
                exp_q[k].push_back({i == N - 1, wbuf[k][idx]});
              end
              wbuf[k].delete();
            end
          end
          if (stalled[k]) begin
            chk("hold_valid", k, 65'(out_valid_w[k]), 65'd1);
            chk("hold_data", k, {out_last_w[k], out_data_w[k]}, held[k]);
          end
          if (out_valid_w[k] && out_ready) begin
            if (exp_q[k].size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_out inst%0d: got %0h expected nothing", k, out_data_w[k]);
            end else begin
              e = exp_q[k].pop_front();
              chk("out_data", k, 65'(out_data_w[k]), 65'(e[63:0]));
              chk("out_last", k, 65'(out_last_w[k]), 65'(e[64]));
              chk("frame_done", k, 65'(frame_done_w[k]), 65'(e[64]));
              pos[k] = e[64] ? 0 : pos[k] + 1;
            end
          end else if (frame_done_w[k]) begin
            checks++; errors++;
            $display("FAIL frame_done_idle inst%0d: got 1 expected 0", k);
          end
          stalled[k] = out_valid_w[k] && !out_ready;
          held[k]    = {out_last_w[k], out_data_w[k]};
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [63:0] d);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 300) begin
      @(negedge CLK);
      acc = in_ready_w[0];
      tick();
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready expected acceptance within 300 cycles");
    end
  endtask

  task automatic send_gap(input logic [63:0] d);
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    send(d);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || out_valid_w[0] || out_valid_w[1])
           && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q[0].size(),
               exp_q[1].size());
    end
  endtask

  initial begin
    int n;
    nGrst    = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hdead_beef;
    rdy_mode = 0;

    // Reset held 3 cycles with in_valid asserted.
    repeat (3) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("rst_wrb", k, 65'(ram_wrb_w[k]), 65'd0);
        chk("rst_in_ready", k, 65'(in_ready_w[k]), 65'd0);
        chk("rst_out_valid", k, 65'(out_valid_w[k]), 65'd0);
        chk("rst_do_rst", k, 65'(do_rst_w[k]), 65'd1);
      end
    end
    nGrst    = 1'b1;
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rel_in_ready", k, 65'(in_ready_w[k]), 65'd1);
      chk("rel_do_rst", k, 65'(do_rst_w[k]), 65'd0);
      chk("rel_do_en", k, 65'(do_en_w[k]), 65'd1);
    end

    // Single frame 0..7 back-to-back; first output 3 cycles after the 8th write.
    for (int i = 0; i < N; i++) send(64'(i));
    in_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) chk("lat_early", k, 65'(out_valid_w[k]), 65'd0);
    tick();
    for (int k = 0; k < 2; k++) chk("lat_first", k, 65'(out_valid_w[k]), 65'd1);
    wait_drain();

    // Writer blocked by two full banks, released by the drain of the older one.
    rdy_mode = 1;
    tick();
    for (int i = 0; i < 2 * N; i++) send({$urandom, $urandom});
    in_valid = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) chk("blk_in_ready", k, 65'(in_ready_w[k]), 65'd0);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    rdy_mode = 0;
    n = 0;
    while (n < 200) begin
      @(negedge CLK);
      if (frame_done_w[0]) break;
      n++;
    end
    chk("blk_fd_seen", 0, 65'(n < 200), 65'd1);
    for (int k = 0; k < 2; k++) chk("blk_same_cycle", k, 65'(in_ready_w[k]), 65'd0);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) chk("blk_next_cycle", k, 65'(in_ready_w[k]), 65'd1);
    tick();
    for (int i = 1; i < N; i++) send({$urandom, $urandom});
    in_valid = 1'b0;
    wait_drain();

    // Random backpressure and input gaps over 4 frames.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) send_gap({$urandom, $urandom});
    in_valid = 1'b0;
    wait_drain();
    rdy_mode = 0;
    tick();

    // Reset while sample 5 of a frame is at the output, then a fresh frame.
    for (int i = 0; i < N; i++) send({$urandom, $urandom});
    in_valid = 1'b0;
    n = 0;
    while (pos[0] != 5 && n < 100) begin tick(); n++; end
    chk("mid_pos_seen", 0, 65'(n < 100), 65'd1);
    nGrst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("mid_out_valid", k, 65'(out_valid_w[k]), 65'd0);
      chk("mid_out_last", k, 65'(out_last_w[k]), 65'd0);
      chk("mid_frame_done", k, 65'(frame_done_w[k]), 65'd0);
      chk("mid_in_ready", k, 65'(in_ready_w[k]), 65'd0);
      chk("mid_wrb", k, 65'(ram_wrb_w[k]), 65'd0);
    end
    tick();
    nGrst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("mid_rel_in_ready", k, 65'(in_ready_w[k]), 65'd1);
    for (int i = 0; i < N; i++) send({$urandom, $urandom});
    in_valid = 1'b0;
    wait_drain();
    for (int k = 0; k < 2; k++) chk("end_wbuf_empty", k, 65'(wbuf[k].size()), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
